// File: rtl/block_splitter.sv
// block_splitter
//   Buffers 128-bit blocks in a small FIFO and emits each one as four 32-bit
//   words, most-significant word first.
//
//   Ports
//     clk_i     : clock, rising edge
//     rst_ni    : asynchronous active-low reset
//     clr_i     : synchronous clear of pointers, count and word index
//     enable_i  : low freezes all state and blocks both handshakes
//     valid_i / ready_o / block_i : upstream block handshake
//     valid_o / ready_i / word_o  : downstream word handshake
//     last_o    : current word is word 3 of its block
//     empty_o   : no block buffered
module block_splitter #(
   parameter int DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         enable_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [127:0] block_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [31:0]  word_o,
   output logic         last_o,
   output logic         empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   // Storage is sized to the full pointer range so a DEPTH of 1 still has a
   // legally indexable array; the spare entry is never written.
   localparam int NE = 1 << PW;
   localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR_C = PW'(DEPTH - 1);

   logic [127:0]  mem_q [NE];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    idx_q, idx_d;

   logic          push;
   logic          out_hs;
   logic          pop;
   logic [127:0]  head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR_C) ? '0 : p + 1'b1;
   endfunction

   // ready_o depends only on registered count and enable_i; a pop in the
   // same cycle does not open a slot until the next cycle.
   assign ready_o = enable_i && (count_q < FULL_C);
   assign valid_o = enable_i && (count_q != '0);
   assign empty_o = (count_q == '0);
   assign last_o  = valid_o && (idx_q == 2'd3);

   // Clear wins over an incoming block: nothing is written that cycle.
   assign push   = valid_i && ready_o && !clr_i;
   assign out_hs = valid_o && ready_i;
   assign pop    = out_hs && (idx_q == 2'd3);

   assign head = mem_q[rd_ptr_q];

   always_comb begin
      word_o = head[127:96];
      case (idx_q)
         2'd0: word_o = head[127:96];
         2'd1: word_o = head[95:64];
         2'd2: word_o = head[63:32];
         2'd3: word_o = head[31:0];
         default: word_o = head[127:96];
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      idx_d    = idx_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         idx_d    = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         // idx wraps 3 -> 0 naturally in two bits
         if (out_hs) idx_d = idx_q + 2'd1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         idx_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NE; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= block_i;
      end
   end

endmodule

// File: tb/tb_block_splitter.sv
module tb_block_splitter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr;
   logic         en;
   logic         vin;
   logic         rdy_in;
   logic [127:0] blk;
   logic         ready_o;
   logic         valid_o;
   logic [31:0]  word_o;
   logic         last_o;
   logic         empty_o;

   block_splitter #(.DEPTH(2)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .clr_i    (clr),
      .enable_i (en),
      .valid_i  (vin),
      .ready_o  (ready_o),
      .block_i  (blk),
      .valid_o  (valid_o),
      .ready_i  (rdy_in),
      .word_o   (word_o),
      .last_o   (last_o),
      .empty_o  (empty_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic        s_valid, s_ready, s_last, s_empty;
   logic [31:0] s_word;
   logic [31:0] got_q[$];
   bit          got_last_q[$];

   typedef struct {
      logic         v;
      logic         r;
      logic         en;
      logic         clr;
      logic [127:0] blk;
      logic         e_valid;
      logic         e_ready;
      logic         e_last;
      logic         e_empty;
      logic [31:0]  e_word;
   } vec_t;

   vec_t tbl[6];

   function automatic logic [31:0] wd(input int k, input int j);
      return 32'hB000_0000 + 32'(k) * 32'd256 + 32'(j);
   endfunction

   function automatic logic [127:0] mkblk(input int k);
      return {wd(k, 0), wd(k, 1), wd(k, 2), wd(k, 3)};
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // Drive inputs at the falling edge, sample outputs 1ns later; the rising
   // edge that follows applies the handshakes recorded here.
   task automatic cyc(input logic v, input logic [127:0] b, input logic r,
                      input logic e, input logic c);
      @(negedge clk);
      vin = v; blk = b; rdy_in = r; en = e; clr = c;
      #1;
      s_valid = valid_o; s_ready = ready_o; s_word = word_o;
      s_last  = last_o;  s_empty = empty_o;
      if (s_valid && r) begin
         got_q.push_back(s_word);
         got_last_q.push_back(s_last);
      end
   endtask

   initial begin
      logic [127:0] b0;
      int  before_c;
      bit  c_done;
      int  nxt;
      bit  started;
      int  bubbles;
      bit  r;

      b0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, b0,      1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 128'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h00112233};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 128'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h44556677};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 128'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h8899AABB};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 128'h0,  1'b1, 1'b1, 1'b1, 1'b0, 32'hCCDDEEFF};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 128'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0};

      rst_n = 1'b0; clr = 1'b0; en = 1'b0; vin = 1'b0; rdy_in = 1'b0; blk = '0;
      repeat (2) @(negedge clk);
      #1 check("rst_ready_en0", {31'b0, ready_o}, 32'd0);
      en = 1'b1;
      #1 check("rst_ready_en1", {31'b0, ready_o}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // single block, table driven
      for (int i = 0; i < 6; i++) begin
         cyc(tbl[i].v, tbl[i].blk, tbl[i].r, tbl[i].en, tbl[i].clr);
         check($sformatf("tbl%0d_valid", i), {31'b0, s_valid}, {31'b0, tbl[i].e_valid});
         check($sformatf("tbl%0d_ready", i), {31'b0, s_ready}, {31'b0, tbl[i].e_ready});
         check($sformatf("tbl%0d_last", i),  {31'b0, s_last},  {31'b0, tbl[i].e_last});
         check($sformatf("tbl%0d_empty", i), {31'b0, s_empty}, {31'b0, tbl[i].e_empty});
         check($sformatf("tbl%0d_word", i),  s_word, tbl[i].e_word);
      end

      // backpressure and fill: A=1, B=2, C=3
      got_q.delete(); got_last_q.delete();
      cyc(1'b1, mkblk(1), 1'b0, 1'b1, 1'b0);
      check("bp_ready_a", {31'b0, s_ready}, 32'd1);
      cyc(1'b1, mkblk(2), 1'b0, 1'b1, 1'b0);
      check("bp_ready_b", {31'b0, s_ready}, 32'd1);
      check("bp_word_a0", s_word, wd(1, 0));
      cyc(1'b1, mkblk(3), 1'b0, 1'b1, 1'b0);
      check("bp_ready_c", {31'b0, s_ready}, 32'd0);
      cyc(1'b1, mkblk(3), 1'b0, 1'b1, 1'b0);
      check("bp_ready_c2", {31'b0, s_ready}, 32'd0);
      check("bp_hold_a0", s_word, wd(1, 0));
      c_done = 1'b0; before_c = -1;
      for (int t = 0; t < 40 && got_q.size() < 12; t++) begin
         cyc(!c_done, mkblk(3), 1'b1, 1'b1, 1'b0);
         if (!c_done && s_ready) begin
            c_done = 1'b1;
            before_c = got_q.size();
         end
      end
      check("bp_c_accept_point", 32'(before_c), 32'd5);
      check("bp_word_count", 32'(got_q.size()), 32'd12);
      for (int i = 0; i < got_q.size() && i < 12; i++)
         check($sformatf("bp_word%0d", i), got_q[i], wd(1 + i / 4, i % 4));
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // stall hold: D=4, ready pattern 1,0,0,1,...
      got_q.delete(); got_last_q.delete();
      cyc(1'b1, mkblk(4), 1'b0, 1'b1, 1'b0);
      for (int t = 0; t < 30 && got_q.size() < 4; t++) begin
         r = (t % 4 == 0) || (t % 4 == 3);
         cyc(1'b0, '0, r, 1'b1, 1'b0);
         if (!r && s_valid) begin
            check($sformatf("stall_word_t%0d", t), s_word, wd(4, got_q.size()));
            check($sformatf("stall_last_t%0d", t), {31'b0, s_last},
                  {31'b0, got_q.size() == 3});
         end
      end
      check("stall_word_count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < got_q.size() && i < 4; i++)
         check($sformatf("stall_order%0d", i), got_q[i], wd(4, i));
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // enable gating: E=5, block 6 offered while disabled
      got_q.delete(); got_last_q.delete();
      cyc(1'b1, mkblk(5), 1'b1, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      for (int t = 0; t < 3; t++) begin
         cyc(1'b1, mkblk(6), 1'b1, 1'b0, 1'b0);
         check($sformatf("en_gap_valid%0d", t), {31'b0, s_valid}, 32'd0);
         check($sformatf("en_gap_ready%0d", t), {31'b0, s_ready}, 32'd0);
      end
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("en_resume_valid", {31'b0, s_valid}, 32'd1);
      check("en_resume_word2", s_word, wd(5, 2));
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("en_word3", s_word, wd(5, 3));
      check("en_last3", {31'b0, s_last}, 32'd1);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("en_empty_after", {31'b0, s_empty}, 32'd1);
      check("en_word_count", 32'(got_q.size()), 32'd4);

      // clear mid-block: F=7, G=8 buffered, H=9 offered with clr
      cyc(1'b1, mkblk(7), 1'b0, 1'b1, 1'b0);
      cyc(1'b1, mkblk(8), 1'b0, 1'b1, 1'b0);
      for (int t = 0; t < 3; t++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("clr_pre_word3", s_word, wd(7, 2));
      cyc(1'b1, mkblk(9), 1'b1, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("clr_empty", {31'b0, s_empty}, 32'd1);
      check("clr_valid", {31'b0, s_valid}, 32'd0);
      cyc(1'b1, mkblk(10), 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("clr_new_valid", {31'b0, s_valid}, 32'd1);
      check("clr_new_word0", s_word, wd(10, 0));
      for (int t = 0; t < 4; t++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("clr_drained", {31'b0, s_empty}, 32'd1);

      // back-to-back streaming of 8 blocks (20..27)
      got_q.delete(); got_last_q.delete();
      nxt = 0; started = 1'b0; bubbles = 0;
      for (int t = 0; t < 100 && got_q.size() < 32; t++) begin
         cyc(nxt < 8, mkblk(20 + nxt), 1'b1, 1'b1, 1'b0);
         if (nxt < 8 && s_ready) nxt++;
         if (started && !s_valid) bubbles++;
         if (s_valid) started = 1'b1;
      end
      check("stream_word_count", 32'(got_q.size()), 32'd32);
      check("stream_bubbles", 32'(bubbles), 32'd0);
      for (int i = 0; i < got_q.size() && i < 32; i++) begin
         check($sformatf("stream_word%0d", i), got_q[i], wd(20 + i / 4, i % 4));
         check($sformatf("stream_last%0d", i), {31'b0, got_last_q[i]}, {31'b0, i % 4 == 3});
      end
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);

      // async reset mid-block
      cyc(1'b1, mkblk(30), 1'b1, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("rstmid_pre_valid", {31'b0, s_valid}, 32'd1);
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rstmid_valid", {31'b0, valid_o}, 32'd0);
      check("rstmid_empty", {31'b0, empty_o}, 32'd1);
      check("rstmid_word", word_o, 32'h0);
      check("rstmid_last", {31'b0, last_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 3; t++) begin
         cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
         check($sformatf("rstmid_after_valid%0d", t), {31'b0, s_valid}, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
